alu_issue_stage: RTL and testbench

// - Producer side of the ALU operand interface: decodes RV32I OP/OP-IMM instructions into rs1/rs2/sub/func3 for the combinational ALU.
// - Sits between register-read and execute; registered output with valid/ready handshake and a 2-entry skid buffer, so in_ready is a flop.
// - Carries rd and an illegal flag alongside the operands for writeback/trap logic.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_skid_buffer.sv | 92 +++++++++
 rtl/alu_issue_stage.sv | 130 +++++++++++++
 tb/tb_alu_issue_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU issue stage.
//   - RV32I opcode constants for OP / OP-IMM
//   - funct3 / funct7 encodings used by the decoder
//   - payload width carried through the skid buffer
//   - skid buffer occupancy state type
package alu_pkg;

  localparam int ALU_XLEN = 32;
  localparam int ALU_RD_W = 5;

  // {illegal, rd, func3, sub, rs1, rs2}
  localparam int PAYLOAD_W = 1 + ALU_RD_W + 3 + 1 + 2 * ALU_XLEN;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/alu_skid_buffer.sv
// alu_skid_buffer: generic 2-entry valid/ready buffer with registered
// in_ready and registered output payload.
//   clk, reset (async, active-high), flush (sync, drops all entries)
//   in_valid / in_ready / in_data   : upstream side
//   out_valid / out_ready / out_data : downstream side, out_data is the head
//
// state      | meaning
// SKID_EMPTY | no entries; out_valid=0, in_ready=1
// SKID_ONE   | head holds one entry; out_valid=1, in_ready=1
// SKID_FULL  | head and tail hold entries; out_valid=1, in_ready=0
module alu_skid_buffer
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         ready_q;
  logic         valid_q;
  logic         push;
  logic         pop;

  assign push = in_valid && ready_q;
  assign pop  = valid_q && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SKID_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else if (flush) begin
      // a push in the same cycle is dropped along with the buffered entries
      state_q <= SKID_EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (push) begin
            head_q  <= in_data;
            valid_q <= 1'b1;
            state_q <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (push && pop) begin
            head_q <= in_data;
          end else if (push) begin
            // head stays put while stalled; new entry parks in the tail
            tail_q  <= in_data;
            ready_q <= 1'b0;
            state_q <= SKID_FULL;
          end else if (pop) begin
            valid_q <= 1'b0;
            state_q <= SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (pop) begin
            head_q  <= tail_q;
            ready_q <= 1'b1;
            state_q <= SKID_ONE;
          end
        end
        default: begin
          state_q <= SKID_EMPTY;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = head_q;

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I OP / OP-IMM instructions into ALU operands
// and issues them through a 2-entry skid buffer.
//   clk, reset (async, active-high), flush (sync)
//   in_valid / in_ready, in_instr, in_rs1_val, in_rs2_val : register-read side
//   out_valid / out_ready, alu_rs1, alu_rs2, alu_sub, alu_func3,
//   out_rd, out_illegal                                    : execute side
//   stat_issued, stat_illegal : handshake counters, present only when
//   ALU_ISSUE_STATS_EN is defined, otherwise tied to 0
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN,
  parameter int RD_W = ALU_RD_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic            alu_sub,
  output logic [2:0]      alu_func3,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal,
  output logic [31:0]     stat_issued,
  output logic [31:0]     stat_illegal
);

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic                 dec_legal;
  logic                 dec_sub;
  logic [XLEN-1:0]      dec_rs2;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 unused_rs1_idx;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // rs1 index is resolved by register-read; only its value arrives here
  assign unused_rs1_idx = ^in_instr[19:15];

  always_comb begin
    dec_legal = 1'b0;
    dec_sub   = 1'b0;
    dec_rs2   = '0;
    case (opcode)
      OP: begin
        dec_legal = (funct7 == FUNCT7_BASE) ||
                    ((funct7 == FUNCT7_ALT) &&
                     ((funct3 == FUNCT3_ADD) || (funct3 == FUNCT3_SR)));
        dec_sub   = in_instr[30];
        dec_rs2   = in_rs2_val;
      end
      OP_IMM: begin
        case (funct3)
          FUNCT3_SLL: dec_legal = (funct7 == FUNCT7_BASE);
          FUNCT3_SR:  dec_legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
          FUNCT3_ADD, FUNCT3_SLT, FUNCT3_SLTU,
          FUNCT3_XOR, FUNCT3_OR, FUNCT3_AND: dec_legal = 1'b1;
          default:    dec_legal = 1'b0;
        endcase
        // bit 30 only selects arithmetic shift; for ADDI it is immediate data
        dec_sub = (funct3 == FUNCT3_SR) && in_instr[30];
        dec_rs2 = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  // illegal entries still flow through, with every operand field zeroed
  assign in_payload = dec_legal ?
                      {1'b0, in_instr[7 +: RD_W], funct3, dec_sub, in_rs1_val, dec_rs2} :
                      {1'b1, {(PAYLOAD_W-1){1'b0}}};

  alu_skid_buffer #(
    .W(PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign {out_illegal, out_rd, alu_func3, alu_sub, alu_rs1, alu_rs2} = out_payload;

`ifdef ALU_ISSUE_STATS_EN
  logic        out_fire;
  logic [31:0] issued_q;
  logic [31:0] illegal_q;

  assign out_fire = out_valid && out_ready;

  // flush does not clear these; only reset does
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_q  <= '0;
      illegal_q <= '0;
    end else if (out_fire) begin
      issued_q <= issued_q + 32'd1;
      if (out_illegal) begin
        illegal_q <= illegal_q + 32'd1;
      end
    end
  end

  assign stat_issued  = issued_q;
  assign stat_illegal = illegal_q;
`else
  assign stat_issued  = '0;
  assign stat_illegal = '0;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_rs1_val = '0;
  logic [31:0] in_rs2_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic        alu_sub;
  logic [2:0]  alu_func3;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic [31:0] stat_issued;
  logic [31:0] stat_illegal;

  alu_issue_stage dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_rs1_val   (in_rs1_val),
    .in_rs2_val   (in_rs2_val),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .alu_rs1      (alu_rs1),
    .alu_rs2      (alu_rs2),
    .alu_sub      (alu_sub),
    .alu_func3    (alu_func3),
    .out_rd       (out_rd),
    .out_illegal  (out_illegal),
    .stat_issued  (stat_issued),
    .stat_illegal (stat_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        ill;
    bit [4:0]  rd;
    bit [2:0]  f3;
    bit        sub;
    bit [31:0] a;
    bit [31:0] b;
  } exp_t;

  exp_t        q[$];
  bit   [31:0] exp_issued;
  bit   [31:0] exp_illegal;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Architectural meaning of an OP / OP-IMM instruction, from the ISA rules.
  function automatic exp_t model_decode(input bit [31:0] ins, input bit [31:0] a, input bit [31:0] b);
    exp_t e;
    bit [6:0] opc = ins[6:0];
    bit [2:0] f3 = ins[14:12];
    bit [6:0] f7 = ins[31:25];
    bit [31:0] imm;
    bit legal = 0;
    e.ill = 0; e.rd = ins[11:7]; e.f3 = f3; e.a = a; e.sub = 0; e.b = 0;
    if (opc == 7'h33) begin
      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      e.b = b;
      e.sub = (f7 == 7'h20);
    end else if (opc == 7'h13) begin
      if (f3 == 3'd1) legal = (f7 == 7'h00);
      else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
      else legal = 1;
      imm = 32'(ins[31:20]);
      e.b = (imm >= 32'd2048) ? imm + 32'hFFFF_F000 : imm;
      e.sub = (f3 == 3'd5) && (f7 == 7'h20);
    end
    if (!legal) begin
      e.ill = 1; e.rd = 0; e.f3 = 0; e.sub = 0; e.a = 0; e.b = 0;
    end
    return e;
  endfunction

  task automatic check_outputs();
    bit [31:0] xi, xl;
`ifdef ALU_ISSUE_STATS_EN
    xi = exp_issued; xl = exp_illegal;
`else
    xi = 0; xl = 0;
`endif
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() != 0) begin
      chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
      chk("out_rd", 32'(out_rd), 32'(q[0].rd));
      chk("alu_func3", 32'(alu_func3), 32'(q[0].f3));
      chk("alu_sub", 32'(alu_sub), 32'(q[0].sub));
      chk("alu_rs1", alu_rs1, q[0].a);
      chk("alu_rs2", alu_rs2, q[0].b);
    end
    chk("stat_issued", stat_issued, xi);
    chk("stat_illegal", stat_illegal, xl);
  endtask

  // Called at a negedge: drive inputs, advance the model over the coming
  // posedge, then compare at the following negedge.
  task automatic cycle(input bit iv, input bit [31:0] ins, input bit [31:0] r1,
                       input bit [31:0] r2, input bit ordy, input bit fl);
    int pre;
    bit pop, push;
    in_valid = iv; in_instr = ins; in_rs1_val = r1; in_rs2_val = r2;
    out_ready = ordy; flush = fl;
    pre = q.size();
    pop = (pre > 0) && ordy;
    push = iv && (pre < 2);
    if (pop) begin
      exp_issued++;
      if (q[0].ill) exp_illegal++;
    end
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(model_decode(ins, r1, r2));
    end
    @(negedge clk);
    check_outputs();
  endtask

  function automatic bit [31:0] rand_instr();
    bit [6:0] opc, f7;
    int s = $urandom_range(0, 9);
    int k = $urandom_range(0, 3);
    opc = (s < 4) ? 7'h33 : (s < 8) ? 7'h13 : 7'($urandom);
    f7 = (k == 1) ? 7'h20 : (k == 3) ? 7'($urandom) : 7'h00;
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  function automatic bit [31:0] rand_legal_add();
    return {7'h00, 5'($urandom), 5'($urandom), 3'd0, 5'($urandom), 7'h33};
  endfunction

  initial begin
    exp_issued = 0; exp_illegal = 0;
    #2 reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_rs2", alu_rs2, 32'd0);
    check_outputs();
    reset = 1'b0;

    // add x3,x1,x2
    cycle(1, 32'h002081B3, 32'd5, 32'd7, 1, 0);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_func3", 32'(alu_func3), 32'd0);
    chk("add_sub", 32'(alu_sub), 32'd0);
    chk("add_rs1", alu_rs1, 32'd5);
    chk("add_rs2", alu_rs2, 32'd7);
    chk("add_rd", 32'(out_rd), 32'd3);
    // sub x3,x1,x2
    cycle(1, 32'h402081B3, 32'd5, 32'd7, 1, 0);
    chk("sub_sub", 32'(alu_sub), 32'd1);
    chk("sub_func3", 32'(alu_func3), 32'd0);
    // addi x1,x0,-1
    cycle(1, 32'hFFF00093, 32'd0, 32'd99, 1, 0);
    chk("addi_rs2", alu_rs2, 32'hFFFF_FFFF);
    chk("addi_sub", 32'(alu_sub), 32'd0);
    // srai x5,x6,4
    cycle(1, 32'h40435293, 32'h8000_0000, 32'd1, 1, 0);
    chk("srai_func3", 32'(alu_func3), 32'd5);
    chk("srai_sub", 32'(alu_sub), 32'd1);
    chk("srai_rs2", alu_rs2, 32'h0000_0404);
    chk("srai_rd", 32'(out_rd), 32'd5);
    // slli with funct7 0100000
    cycle(1, 32'h40001093, 32'd3, 32'd4, 1, 0);
    chk("slli_bad_ill", 32'(out_illegal), 32'd1);
    chk("slli_bad_rs1", alu_rs1, 32'd0);
    chk("slli_bad_rd", 32'(out_rd), 32'd0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // stall with streaming input
    cycle(1, 32'h002081B3, 32'd11, 32'd12, 0, 0);
    chk("stall1_ready", 32'(in_ready), 32'd1);
    cycle(1, 32'h40208233, 32'd21, 32'd22, 0, 0);
    chk("stall2_ready", 32'(in_ready), 32'd0);
    chk("stall2_rd", 32'(out_rd), 32'd3);
    cycle(1, 32'h002082B3, 32'd31, 32'd32, 0, 0);
    cycle(1, 32'h00208333, 32'd41, 32'd42, 0, 0);
    chk("stall4_rd", 32'(out_rd), 32'd3);
    chk("stall4_rs1", alu_rs1, 32'd11);
    cycle(0, 0, 0, 0, 1, 0);
    chk("release_rd", 32'(out_rd), 32'd4);
    chk("release_rs1", alu_rs1, 32'd21);
    cycle(0, 0, 0, 0, 1, 0);
    chk("release_empty", 32'(out_valid), 32'd0);

    // flush while full with in_valid high
    cycle(1, 32'h002081B3, 32'd1, 32'd2, 0, 0);
    cycle(1, 32'h002081B3, 32'd3, 32'd4, 0, 0);
    cycle(1, 32'h002081B3, 32'd5, 32'd6, 0, 1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    cycle(0, 0, 0, 0, 1, 0);
    chk("flush_after", 32'(out_valid), 32'd0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom,
            $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3);
    end

    // counter run from a clean reset: 10 legal + 2 illegal
    reset = 1'b1;
    q.delete(); exp_issued = 0; exp_illegal = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4 || i == 9) cycle(1, 32'h40001093, $urandom, $urandom, 1, 0);
      else cycle(1, rand_legal_add(), $urandom, $urandom, 1, 0);
    end
    cycle(0, 0, 0, 0, 1, 0);
`ifdef ALU_ISSUE_STATS_EN
    chk("stats_issued12", stat_issued, 32'd12);
    chk("stats_illegal2", stat_illegal, 32'd2);
`else
    chk("stats_issued_off", stat_issued, 32'd0);
    chk("stats_illegal_off", stat_illegal, 32'd0);
`endif

    // reset asserted mid-stream clears immediately
    cycle(1, 32'h002081B3, 32'd7, 32'd8, 0, 0);
    cycle(1, 32'h402081B3, 32'd9, 32'd10, 0, 0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    q.delete(); exp_issued = 0; exp_illegal = 0;
    #1;
    chk("amid_valid", 32'(out_valid), 32'd0);
    chk("amid_ready", 32'(in_ready), 32'd1);
    chk("amid_rs1", alu_rs1, 32'd0);
    chk("amid_rd", 32'(out_rd), 32'd0);
    chk("amid_stat", stat_issued, 32'd0);
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    cycle(1, 32'hFFF00093, 32'd0, 32'd0, 1, 0);
    chk("post_reset_rs2", alu_rs2, 32'hFFFF_FFFF);
    cycle(0, 0, 0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
